// File: rtl/rv32i_regfile_arbiter.sv
// rv32i_regfile_arbiter
//   Purpose : arbitrates two register-file write sources (A = execute writeback,
//             B = load return) onto one registered write port, and keeps a
//             load scoreboard that stalls decode on pending load destinations.
//   Latency : ready is combinational; an accepted write appears on wr/rd_addr/rd
//             one cycle later. Scoreboard set/clear takes effect at the clock edge.
//   Backpressure: at most one of a_ready/b_ready is high per cycle; the loser
//             simply sees ready=0 and must hold its request.
//   Ports   : clk, rst_n (async, active-low)
//             a_valid/a_ready/a_addr/a_data   port A write request
//             b_valid/b_ready/b_addr/b_data   port B write request (clears busy)
//             rsv_valid/rsv_addr              load-issue reservation (sets busy)
//             rs1_addr/rs2_addr -> stall      decode hazard check
//             wr/rd_addr/rd                   register-file write port
//             busy                            scoreboard, bit n = reg n pending
module rv32i_regfile_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        stall,
  output logic        wr,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd,
  output logic [31:0] busy
);

  // prio_b_q = 1 means B wins the next contended cycle (A was granted last).
  // Reset to 0 so A wins the first contention.
  logic        prio_b_q, prio_b_d;
  logic        wr_q, wr_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] busy_q, busy_d;

  logic        a_win;
  logic        a_xfer, b_xfer;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  // Grant logic. Readies are forced low during reset so nothing is accepted
  // while state is being cleared.
  always_comb begin
    a_win   = !b_valid || FIXED_PRIO || !prio_b_q;
    a_ready = rst_n && a_valid && a_win;
    b_ready = rst_n && b_valid && !(a_valid && a_win);
    a_xfer  = a_valid && a_ready;
    b_xfer  = b_valid && b_ready;
  end

  // Write-stage mux; writes to x0 are accepted but dropped here.
  always_comb begin
    w_addr = a_xfer ? a_addr : b_addr;
    w_data = a_xfer ? a_data : b_data;
    w_en   = (a_xfer || b_xfer) && (w_addr != 5'd0);
  end

  always_comb begin
    prio_b_d  = prio_b_q;
    wr_d      = w_en;
    rd_addr_d = rd_addr_q;
    rd_d      = rd_q;
    busy_d    = busy_q;

    if (a_xfer)      prio_b_d = 1'b1;
    else if (b_xfer) prio_b_d = 1'b0;

    if (w_en) begin
      rd_addr_d = w_addr;
      rd_d      = w_data;
    end

    // Clear first, then set: a new reservation supersedes the returning load.
    if (b_xfer)                          busy_d[b_addr]   = 1'b0;
    if (rsv_valid && rsv_addr != 5'd0)   busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b_q  <= 1'b0;
      wr_q      <= 1'b0;
      rd_addr_q <= 5'd0;
      rd_q      <= 32'd0;
      busy_q    <= 32'd0;
    end else begin
      prio_b_q  <= prio_b_d;
      wr_q      <= wr_d;
      rd_addr_q <= rd_addr_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
    end
  end

  assign wr      = wr_q;
  assign rd_addr = rd_addr_q;
  assign rd      = rd_q;
  assign busy    = busy_q;
  assign stall   = busy_q[rs1_addr] | busy_q[rs2_addr];

endmodule

// File: tb/tb_rv32i_regfile_arbiter.sv
module tb_rv32i_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, rsv_valid;
  logic [4:0]  a_addr, b_addr, rsv_addr, rs1_addr, rs2_addr;
  logic [31:0] a_data, b_data;

  logic        a_ready, b_ready, stall, wr;
  logic [4:0]  rd_addr;
  logic [31:0] rd, busy;

  logic        fp_a_ready, fp_b_ready, fp_stall, fp_wr;
  logic [4:0]  fp_rd_addr;
  logic [31:0] fp_rd, fp_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32i_regfile_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .stall(stall), .wr(wr), .rd_addr(rd_addr), .rd(rd), .busy(busy)
  );

  rv32i_regfile_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(fp_a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(fp_b_ready), .b_addr(b_addr), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .stall(fp_stall), .wr(fp_wr), .rd_addr(fp_rd_addr), .rd(fp_rd), .busy(fp_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; rsv_valid = 0;
    a_addr = 0; b_addr = 0; rsv_addr = 0;
    a_data = 0; b_data = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    rs1_addr = 0; rs2_addr = 0;
    // Requests during reset must not be granted.
    a_valid = 1; b_valid = 1;
    #2;
    check_eq("rst_a_ready", a_ready, 0);
    check_eq("rst_b_ready", b_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr", wr, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_rd", rd, 0);
    check_eq("rst_stall", stall, 0);
    idle();
    tick();
    tick();
    #2 rst_n = 1;
    tick();

    // Round-robin contention: A,B,A,B; fixed-priority instance always A.
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_addr = 5'd3; a_data = 32'h0000_0033;
      b_valid = 1; b_addr = 5'd4; b_data = 32'h0000_0044;
      #1;
      check_eq($sformatf("rr_a_ready%0d", i), a_ready, (i % 2 == 0));
      check_eq($sformatf("rr_b_ready%0d", i), b_ready, (i % 2 == 1));
      check_eq($sformatf("fp_a_ready%0d", i), fp_a_ready, 1);
      check_eq($sformatf("fp_b_ready%0d", i), fp_b_ready, 0);
      tick();
      check_eq($sformatf("rr_wr%0d", i), wr, 1);
      check_eq($sformatf("rr_rd_addr%0d", i), rd_addr, (i % 2 == 0) ? 32'd3 : 32'd4);
      check_eq($sformatf("rr_rd%0d", i), rd, (i % 2 == 0) ? 32'h33 : 32'h44);
    end
    idle();
    #1;
    check_eq("idle_ready", {a_ready, b_ready}, 0);
    tick();
    check_eq("idle_wr", wr, 0);

    // A only.
    a_valid = 1; a_addr = 5'd5; a_data = 32'h1234_5678;
    #1;
    check_eq("a_only_ready", a_ready, 1);
    check_eq("a_only_b_ready", b_ready, 0);
    tick();
    check_eq("a_only_wr", wr, 1);
    check_eq("a_only_rd_addr", rd_addr, 5);
    check_eq("a_only_rd", rd, 32'h1234_5678);
    idle();
    tick();
    check_eq("a_only_wr_after", wr, 0);

    // Scoreboard: reserve x7, stall, then B return clears.
    rsv_valid = 1; rsv_addr = 5'd7;
    tick();
    idle();
    rs1_addr = 5'd7;
    #1;
    check_eq("sb_busy_set", busy, 32'h0000_0080);
    check_eq("sb_stall", stall, 1);
    b_valid = 1; b_addr = 5'd7; b_data = 32'hDEAD_BEEF;
    #1;
    check_eq("sb_b_ready", b_ready, 1);
    tick();
    idle();
    #1;
    check_eq("sb_busy_clr", busy, 0);
    check_eq("sb_stall_clr", stall, 0);
    check_eq("sb_wr", wr, 1);
    check_eq("sb_rd_addr", rd_addr, 7);
    check_eq("sb_rd", rd, 32'hDEAD_BEEF);
    rs1_addr = 0;

    // Collision: reserve x9 while B returns x9 -> stays busy.
    rsv_valid = 1; rsv_addr = 5'd9;
    b_valid = 1; b_addr = 5'd9; b_data = 32'h0000_0099;
    rs2_addr = 5'd9;
    #1;
    check_eq("col_b_ready", b_ready, 1);
    tick();
    idle();
    #1;
    check_eq("col_busy", busy, 32'h0000_0200);
    check_eq("col_stall_rs2", stall, 1);
    check_eq("col_wr", wr, 1);
    check_eq("col_rd_addr", rd_addr, 9);
    // Reserving an already-busy register keeps it busy.
    rsv_valid = 1; rsv_addr = 5'd9;
    tick();
    idle();
    check_eq("rersv_busy", busy, 32'h0000_0200);
    // A later lone B return clears it.
    b_valid = 1; b_addr = 5'd9; b_data = 32'h0000_0999;
    tick();
    idle();
    check_eq("ret2_busy", busy, 0);
    check_eq("ret2_rd", rd, 32'h0000_0999);
    rs2_addr = 0;

    // x0: write accepted but dropped; reservation of x0 ignored.
    a_valid = 1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
    rsv_valid = 1; rsv_addr = 5'd0;
    rs1_addr = 5'd0;
    #1;
    check_eq("x0_a_ready", a_ready, 1);
    tick();
    idle();
    #1;
    check_eq("x0_wr", wr, 0);
    check_eq("x0_rd_addr_hold", rd_addr, 9);
    check_eq("x0_rd_hold", rd, 32'h0000_0999);
    check_eq("x0_busy", busy, 0);
    check_eq("x0_stall", stall, 0);

    // Async reset with pending write and reservation; A granted last so the
    // pointer favours B until reset restores it.
    rsv_valid = 1; rsv_addr = 5'd7;
    a_valid = 1; a_addr = 5'd1; a_data = 32'h0000_0011;
    rs1_addr = 5'd7;
    tick();
    idle();
    check_eq("ar_pre_busy", busy, 32'h0000_0080);
    check_eq("ar_pre_wr", wr, 1);
    #2 rst_n = 0;
    #1;
    check_eq("ar_busy", busy, 0);
    check_eq("ar_wr", wr, 0);
    check_eq("ar_rd_addr", rd_addr, 0);
    check_eq("ar_stall", stall, 0);
    tick();
    #2 rst_n = 1;
    rs1_addr = 0;
    a_valid = 1; a_addr = 5'd3; a_data = 32'h0000_0033;
    b_valid = 1; b_addr = 5'd4; b_data = 32'h0000_0044;
    #1;
    check_eq("ar_first_a_ready", a_ready, 1);
    check_eq("ar_first_b_ready", b_ready, 0);
    tick();
    idle();
    check_eq("ar_first_wr", wr, 1);
    check_eq("ar_first_rd_addr", rd_addr, 3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
